// File: rtl/morse_symbol_decoder.sv
// Morse key decoder: times presses/gaps in prescaled units, emits dot/dash/letter-gap/word-gap pulses
// and a packed code word per letter. Define MORSE_DEBOUNCE_EN to add a DEB_CYCLES input debounce.
module morse_symbol_decoder #(
    parameter int TICK_DIV   = 5_000_000,
    parameter int CNT_BITS   = 5,
    parameter int DOT_UNITS  = 2,
    parameter int LG_UNITS   = 3,
    parameter int WG_UNITS   = 7,
    parameter int MAX_SYM    = 5,
    parameter int DEB_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         b,
    output logic                         dot,
    output logic                         dash,
    output logic                         LG,
    output logic                         WG,
    output logic                         sym_valid,
    output logic [MAX_SYM-1:0]           sym_bits,
    output logic [$clog2(MAX_SYM+1)-1:0] sym_len,
    output logic                         sym_err
);

    localparam int                  PRE_W    = $clog2(TICK_DIV);
    localparam int                  LEN_W    = $clog2(MAX_SYM + 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_BITS-1:0] DOT_LIM  = CNT_BITS'(DOT_UNITS);
    localparam logic [CNT_BITS-1:0] LG_PRE   = CNT_BITS'(LG_UNITS - 1);
    localparam logic [CNT_BITS-1:0] WG_PRE   = CNT_BITS'(WG_UNITS - 1);
    localparam logic [LEN_W-1:0]    LEN_MAX  = LEN_W'(MAX_SYM);

    if (TICK_DIV < 2 || CNT_BITS < 1 || DOT_UNITS < 1 || LG_UNITS < 1 ||
        WG_UNITS <= LG_UNITS || WG_UNITS >= (1 << CNT_BITS) ||
        MAX_SYM < 1 || DEB_CYCLES < 1) begin : g_param_check
        $error("morse_symbol_decoder: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [MAX_SYM-1:0] put_elem(input logic [MAX_SYM-1:0] bits,
                                                    input logic [LEN_W-1:0]   pos,
                                                    input logic               val);
        logic [MAX_SYM-1:0] r;
        r = bits;
        for (int k = 0; k < MAX_SYM; k++) begin
            if (pos == LEN_W'(k)) r[k] = val;
        end
        return r;
    endfunction

    // Stage p0/p1: two-flop synchroniser for the asynchronous key
    logic b_meta_p0, b_sync_p1;
    logic bs, bs_dly_p2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_meta_p0 <= 1'b0;
            b_sync_p1 <= 1'b0;
        end else begin
            b_meta_p0 <= b;
            b_sync_p1 <= b_meta_p0;
        end
    end

`ifdef MORSE_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    logic [DEB_W-1:0] deb_cnt;
    logic             bs_deb;

    // A new level is accepted only after DEB_CYCLES consecutive cycles of disagreement
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt <= '0;
            bs_deb  <= 1'b0;
        end else if (b_sync_p1 == bs_deb) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            deb_cnt <= '0;
            bs_deb  <= b_sync_p1;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign bs = bs_deb;
`else
    assign bs = b_sync_p1;
`endif

    // Stage p2: delayed level for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bs_dly_p2 <= 1'b0;
        else          bs_dly_p2 <= bs;
    end

    logic rise, fall, key_edge;
    assign rise     = bs & ~bs_dly_p2;
    assign fall     = ~bs & bs_dly_p2;
    assign key_edge = rise | fall;

    logic [PRE_W-1:0]    presc;
    logic [CNT_BITS-1:0] unit_cnt;
    logic                tick, lg_hit, wg_hit;

    assign tick   = (presc == PRE_LAST);
    assign lg_hit = tick && (unit_cnt == LG_PRE);
    assign wg_hit = tick && (unit_cnt == WG_PRE);

    // Every key edge restarts the unit measurement from zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc    <= '0;
            unit_cnt <= '0;
        end else if (key_edge) begin
            presc    <= '0;
            unit_cnt <= '0;
        end else if (tick) begin
            presc    <= '0;
            unit_cnt <= sat_inc(unit_cnt);
        end else begin
            presc    <= presc + 1'b1;
        end
    end

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = PRESS;
            PRESS:   if (fall) state_d = GAP;
            GAP: begin
                if (rise)        state_d = PRESS;
                else if (wg_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic store_el, is_dash, lg_fire, wg_fire;

    always_comb begin
        store_el = 1'b0;
        is_dash  = 1'b0;
        lg_fire  = 1'b0;
        wg_fire  = 1'b0;
        case (state_q)
            PRESS: begin
                store_el = fall;
                is_dash  = fall && (unit_cnt >= DOT_LIM);
            end
            GAP: begin
                lg_fire = lg_hit;
                wg_fire = wg_hit;
            end
            default: ;
        endcase
    end

    logic [MAX_SYM-1:0] elem_bits;
    logic [LEN_W-1:0]   elem_len;
    logic               elem_ovf;

    // Letter accumulator; emptied as the letter is handed to the output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            elem_bits <= '0;
            elem_len  <= '0;
            elem_ovf  <= 1'b0;
        end else if (lg_fire) begin
            elem_bits <= '0;
            elem_len  <= '0;
            elem_ovf  <= 1'b0;
        end else if (store_el) begin
            if (elem_len < LEN_MAX) begin
                elem_bits <= put_elem(elem_bits, elem_len, is_dash);
                elem_len  <= elem_len + 1'b1;
            end else begin
                elem_ovf  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dot       <= 1'b0;
            dash      <= 1'b0;
            LG        <= 1'b0;
            WG        <= 1'b0;
            sym_valid <= 1'b0;
            sym_bits  <= '0;
            sym_len   <= '0;
            sym_err   <= 1'b0;
        end else begin
            dot       <= store_el & ~is_dash;
            dash      <= store_el & is_dash;
            LG        <= lg_fire;
            WG        <= wg_fire;
            sym_valid <= lg_fire;
            if (lg_fire) begin
                sym_bits <= elem_bits;
                sym_len  <= elem_len;
                sym_err  <= elem_ovf;
            end
        end
    end

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Directed bench for morse_symbol_decoder: letter table plus hand sequences for reset,
// latency, gap/rise coincidence and (with MORSE_DEBOUNCE_EN) glitch rejection.
module tb_morse_symbol_decoder;

`ifdef MORSE_DEBOUNCE_EN
    localparam int TDIV = 32;
    localparam int DEB  = 16;
`else
    localparam int TDIV = 4;
    localparam int DEB  = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       b = 1'b0;
    logic       dot, dash, LG, WG, sym_valid, sym_err;
    logic [4:0] sym_bits;
    logic [2:0] sym_len;

    morse_symbol_decoder #(
        .TICK_DIV(TDIV), .CNT_BITS(5), .DOT_UNITS(2), .LG_UNITS(3),
        .WG_UNITS(7), .MAX_SYM(5), .DEB_CYCLES(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .b(b),
        .dot(dot), .dash(dash), .LG(LG), .WG(WG), .sym_valid(sym_valid),
        .sym_bits(sym_bits), .sym_len(sym_len), .sym_err(sym_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_dot = 0, n_dash = 0, n_lg = 0, n_wg = 0, n_sv = 0, n_viol = 0;
    logic [8:0] caps[$];

    always @(negedge clk) begin
        if (reset_n) begin
            if (dot)       n_dot++;
            if (dash)      n_dash++;
            if (LG)        n_lg++;
            if (WG)        n_wg++;
            if (sym_valid) begin
                n_sv++;
                caps.push_back({sym_err, sym_len, sym_bits});
            end
            if ((dot && dash) || (LG && WG) || (LG != sym_valid)) n_viol++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int cyc);
        b = lvl;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic send_letter(input int n, input logic [7:0] pat, input int gap);
        for (int i = 0; i < n; i++) begin
            hold(1'b1, (pat[i] ? 3 : 1) * TDIV);
            hold(1'b0, ((i == n - 1) ? gap : 1) * TDIV);
        end
    endtask

    typedef struct {
        int         n_el;
        logic [7:0] pat;
        int         gap;
        int         e_dot;
        int         e_dash;
        int         e_lg;
        int         e_wg;
        int         e_bits;
        int         e_len;
        int         e_err;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    int s_dot, s_dash, s_lg, s_wg, s_sv;
    logic [8:0] cap_a, cap_b;

    task automatic snap();
        s_dot = n_dot; s_dash = n_dash; s_lg = n_lg; s_wg = n_wg; s_sv = n_sv;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{2, 8'b0000_0010, 4, 1, 1, 1, 0, 5'b00010, 2, 0};
        vecs[1] = '{3, 8'b0000_0000, 8, 3, 0, 1, 1, 5'b00000, 3, 0};
        vecs[2] = '{6, 8'b0011_1111, 8, 0, 6, 1, 1, 5'b11111, 5, 1};
        vecs[3] = '{1, 8'b0000_0001, 8, 0, 1, 1, 1, 5'b00001, 1, 0};
        vecs[4] = '{5, 8'b0000_0000, 8, 5, 0, 1, 1, 5'b00000, 5, 0};
        vecs[5] = '{4, 8'b0000_0110, 4, 2, 2, 1, 0, 5'b00110, 4, 0};
        vecs[6] = '{1, 8'b0000_0000, 8, 1, 0, 1, 1, 5'b00000, 1, 0};

        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", int'({dot, dash, LG, WG, sym_valid, sym_bits, sym_len, sym_err}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // dot latency from raw key release
        b = 1'b1;
        repeat (TDIV) @(negedge clk);
        b = 1'b0;
        repeat (2 + DEB) @(posedge clk);
        #1;
        chk("lat_dot_early", int'(dot), 0);
        @(posedge clk);
        #1;
        chk("lat_dot", int'(dot), 1);
        chk("lat_dash", int'(dash), 0);
        repeat (9 * TDIV) @(negedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            snap();
            send_letter(vecs[i].n_el, vecs[i].pat, vecs[i].gap);
            #1;
            chk($sformatf("v%0d_dot", i),  n_dot - s_dot,   vecs[i].e_dot);
            chk($sformatf("v%0d_dash", i), n_dash - s_dash, vecs[i].e_dash);
            chk($sformatf("v%0d_lg", i),   n_lg - s_lg,     vecs[i].e_lg);
            chk($sformatf("v%0d_wg", i),   n_wg - s_wg,     vecs[i].e_wg);
            chk($sformatf("v%0d_sv", i),   n_sv - s_sv,     1);
            cap_a = (caps.size() > 0) ? caps[caps.size() - 1] : 9'h1ff;
            chk($sformatf("v%0d_bits", i), int'(cap_a[4:0]), vecs[i].e_bits);
            chk($sformatf("v%0d_len", i),  int'(cap_a[7:5]), vecs[i].e_len);
            chk($sformatf("v%0d_err", i),  int'(cap_a[8]),   vecs[i].e_err);
        end

        // key pressed exactly on the letter-gap tick
        snap();
        send_letter(3, 8'b0000_0101, 3);
        send_letter(1, 8'b0000_0000, 8);
        #1;
        chk("coinc_lg", n_lg - s_lg, 2);
        chk("coinc_sv", n_sv - s_sv, 2);
        chk("coinc_wg", n_wg - s_wg, 1);
        chk("coinc_dot", n_dot - s_dot, 2);
        chk("coinc_dash", n_dash - s_dash, 2);
        chk("coinc_caps", (caps.size() >= 2) ? 1 : 0, 1);
        if (caps.size() >= 2) begin
            cap_a = caps[caps.size() - 2];
            cap_b = caps[caps.size() - 1];
            chk("coinc_first_bits", int'(cap_a[4:0]), 5);
            chk("coinc_first_len",  int'(cap_a[7:5]), 3);
            chk("coinc_next_bits",  int'(cap_b[4:0]), 0);
            chk("coinc_next_len",   int'(cap_b[7:5]), 1);
        end

        // reset in the middle of a letter
        hold(1'b1, 3 * TDIV);
        hold(1'b0, TDIV);
        b = 1'b1;
        repeat (TDIV) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_outputs", int'({dot, dash, LG, WG, sym_valid, sym_bits, sym_len, sym_err}), 0);
        b = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_unit_cnt", int'(dut.unit_cnt), 0);
        snap();
        repeat (10 * TDIV) @(negedge clk);
        #1;
        chk("rst_no_dot", n_dot - s_dot, 0);
        chk("rst_no_dash", n_dash - s_dash, 0);
        chk("rst_no_sv", n_sv - s_sv, 0);
        chk("rst_len_held", int'(sym_len), 0);

`ifdef MORSE_DEBOUNCE_EN
        snap();
        hold(1'b1, 10);
        hold(1'b0, 10 * TDIV);
        #1;
        chk("deb_glitch_dot", n_dot - s_dot, 0);
        chk("deb_glitch_dash", n_dash - s_dash, 0);
        chk("deb_glitch_sv", n_sv - s_sv, 0);
        snap();
        hold(1'b1, 20);
        hold(1'b0, 9 * TDIV);
        #1;
        chk("deb_hold_dot", n_dot - s_dot, 1);
        chk("deb_hold_dash", n_dash - s_dash, 0);
        chk("deb_hold_sv", n_sv - s_sv, 1);
        cap_a = (caps.size() > 0) ? caps[caps.size() - 1] : 9'h1ff;
        chk("deb_hold_len", int'(cap_a[7:5]), 1);
`endif

        chk("invariants", n_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
